// File: rtl/md_unit_ctrl_pkg.sv
// md_unit_ctrl_pkg: start-code encodings, FSM states and default latencies for the mult/div unit
package md_unit_ctrl_pkg;
  typedef enum logic [3:0] {
    MD_NO_START = 4'd0,
    MD_MULT     = 4'd1,
    MD_MULTU    = 4'd2,
    MD_DIV      = 4'd3,
    MD_DIVU     = 4'd4,
    MD_MTHI     = 4'd5,
    MD_MTLO     = 4'd6
  } md_sel_e;
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MULT_RUN = 2'd1,
    S_DIV_RUN  = 2'd2
  } md_state_e;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 4;
endpackage

// File: rtl/md_unit_ctrl_arith.sv
// md_arith: combinational 32x32 product and quotient/remainder, signed or unsigned, with div-by-zero flag
module md_arith (
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] prod_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o,
  output logic        dz_o
);
  logic signed [63:0] a_s, b_s, p_s;
  logic signed [31:0] q_s, r_s;
  logic               ovf;
  assign a_s  = {{32{a_i[31]}}, a_i};
  assign b_s  = {{32{b_i[31]}}, b_i};
  assign p_s  = a_s * b_s;
  assign dz_o = b_i == 32'd0;
  // 0x80000000 / -1 does not fit; pin it rather than trust the simulator's overflow behaviour
  assign ovf  = signed_i && a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF;
  assign q_s  = (dz_o || ovf) ? 32'sd0 : $signed(a_i) / $signed(b_i);
  assign r_s  = (dz_o || ovf) ? 32'sd0 : $signed(a_i) % $signed(b_i);
  assign prod_o = signed_i ? p_s : {32'd0, a_i} * {32'd0, b_i};
  assign quo_o  = ovf ? a_i : dz_o ? 32'd0 : signed_i ? q_s : a_i / b_i;
  assign rem_o  = ovf ? 32'd0 : dz_o ? 32'd0 : signed_i ? r_s : a_i % b_i;
endmodule

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: E-stage mult/div sequencer owning HI/LO; fixed-latency runs with busy/stall export.
// Optional MD_UNIT_CANCEL_EN adds cancel_i to suppress starts and abort runs.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = MD_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MD_UNIT_CANCEL_EN
  input  logic        cancel_i,
`endif
  input  logic [3:0]  md_sel_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        start_o,
  output logic        md_stall_o
);
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [63:0]      res_q, res_d;
  logic             dz_q, dz_d;
  logic             cancel, is_mult, is_div, sgn, dz;
  logic [63:0]      prod;
  logic [31:0]      quo, rem;
`ifdef MD_UNIT_CANCEL_EN
  assign cancel = cancel_i;
`else
  assign cancel = 1'b0;
`endif
  assign is_mult    = md_sel_E == MD_MULT || md_sel_E == MD_MULTU;
  assign is_div     = md_sel_E == MD_DIV  || md_sel_E == MD_DIVU;
  assign sgn        = md_sel_E == MD_MULT || md_sel_E == MD_DIV;
  assign busy_o     = state_q != S_IDLE;
  assign start_o    = !busy_o && !cancel && (is_mult || is_div);
  assign md_stall_o = start_o || busy_o;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  md_arith u_arith (
    .signed_i (sgn),
    .a_i      (rs_E),
    .b_i      (rt_E),
    .prod_o   (prod),
    .quo_o    (quo),
    .rem_o    (rem),
    .dz_o     (dz)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    dz_d    = dz_q;
    if (!busy_o) begin
      if (start_o) begin
        state_d = is_mult ? S_MULT_RUN : S_DIV_RUN;
        cnt_d   = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        res_d   = is_mult ? prod : {rem, quo};
        dz_d    = !is_mult && dz;
      end else if (!cancel) begin
        hi_d = md_sel_E == MD_MTHI ? rs_E : hi_q;
        lo_d = md_sel_E == MD_MTLO ? rs_E : lo_q;
      end
    end else if (cancel) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d      = S_IDLE;
        {hi_d, lo_d} = dz_q ? {hi_q, lo_q} : res_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end
  // The hazard unit must hold md-class instructions in D while busy
  always_ff @(posedge clk)
    if (!reset && busy_o)
      assert (md_sel_E == 4'd0)
      else $warning("md_unit_ctrl: start code %0d ignored while busy", md_sel_E);
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed vectors for md_unit_ctrl with hand-computed HI/LO and busy timing
module tb_md_unit_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cancel = 1'b0;
  logic [3:0]  md_sel = 4'd0;
  logic [31:0] rs = '0, rt = '0;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, start_o, md_stall_o;
  int          nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  md_unit_ctrl dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MD_UNIT_CANCEL_EN
    .cancel_i   (cancel),
`endif
    .md_sel_E   (md_sel),
    .rs_E       (rs),
    .rt_E       (rt),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .busy_o     (busy_o),
    .start_o    (start_o),
    .md_stall_o (md_stall_o)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    md_sel = s;
    rs     = a;
    rt     = b;
    #1;
  endtask
  task automatic run_busy(input string tag, input int n);
    int c = 0;
    while (busy_o && c < 40) begin
      c++;
      step();
    end
    chk(tag, 64'(c), 64'(n));
  endtask
  task automatic op(input string tag, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                    input int n, input logic [31:0] ehi, input logic [31:0] elo);
    issue(s, a, b);
    chk({tag, " start"}, 64'(start_o), 64'(1));
    step();
    md_sel = 4'd0;
    run_busy({tag, " busy"}, n);
    chk({tag, " hi"}, 64'(hi_o), 64'(ehi));
    chk({tag, " lo"}, 64'(lo_o), 64'(elo));
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst hi", 64'(hi_o), 64'(0));
    chk("rst lo", 64'(lo_o), 64'(0));
    chk("rst busy", 64'(busy_o), 64'(0));
    chk("rst stall", 64'(md_stall_o), 64'(0));
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    chk("mult stall T", 64'(md_stall_o), 64'(1));
    step();
    md_sel = 4'd0;
    chk("mult hold hi", 64'(hi_o), 64'(0));
    run_busy("mult busy", 5);
    chk("mult hi", 64'(hi_o), 64'(32'hFFFF_FFFF));
    chk("mult lo", 64'(lo_o), 64'(32'hFFFF_FFFE));
    op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h1, 32'hFFFF_FFFE);
    op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    issue(4'd5, 32'h11, 32'd0);
    chk("mthi start", 64'(start_o), 64'(0));
    step();
    issue(4'd6, 32'h22, 32'd0);
    step();
    md_sel = 4'd0;
    chk("mtlo busy", 64'(busy_o), 64'(0));
    chk("mthi hi", 64'(hi_o), 64'(32'h11));
    chk("mtlo lo", 64'(lo_o), 64'(32'h22));
    op("divz", 4'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22);
    op("dovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    issue(4'd7, 32'd1, 32'd1);
    chk("code7 start", 64'(start_o), 64'(0));
    step();
    md_sel = 4'd0;
    chk("code7 busy", 64'(busy_o), 64'(0));
    issue(4'd1, 32'd6, 32'd7);
    chk("mb stall T", 64'(md_stall_o), 64'(1));
    step();
    md_sel = 4'd0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) issue(4'd6, 32'h5, 32'd0);
      #1;
      chk($sformatf("mb stall T+%0d", i), 64'(md_stall_o), 64'(1));
      chk($sformatf("mb start T+%0d", i), 64'(start_o), 64'(0));
      step();
      md_sel = 4'd0;
    end
    #1;
    chk("mb busy end", 64'(busy_o), 64'(0));
    chk("mb stall end", 64'(md_stall_o), 64'(0));
    chk("mb lo", 64'(lo_o), 64'(42));
    chk("mb hi", 64'(hi_o), 64'(0));
    issue(4'd3, 32'd100, 32'd7);
    step();
    md_sel = 4'd0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmid busy", 64'(busy_o), 64'(0));
    chk("rmid hi", 64'(hi_o), 64'(0));
    chk("rmid lo", 64'(lo_o), 64'(0));
    op("rmul", 4'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    issue(4'd1, 32'd2, 32'd3);
    step();
    md_sel = 4'd0;
    repeat (4) step();
    issue(4'd3, 32'd9, 32'd2);
    chk("b2b commit start", 64'(start_o), 64'(0));
    step();
    chk("b2b busy", 64'(busy_o), 64'(0));
    chk("b2b lo", 64'(lo_o), 64'(6));
    chk("b2b start", 64'(start_o), 64'(1));
    step();
    md_sel = 4'd0;
    run_busy("b2b div busy", 10);
    chk("b2b div hi", 64'(hi_o), 64'(1));
    chk("b2b div lo", 64'(lo_o), 64'(4));
`ifdef MD_UNIT_CANCEL_EN
    issue(4'd1, 32'd6, 32'd7);
    step();
    md_sel = 4'd0;
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel busy", 64'(busy_o), 64'(0));
    chk("cancel hi", 64'(hi_o), 64'(1));
    chk("cancel lo", 64'(lo_o), 64'(4));
    cancel = 1'b1;
    issue(4'd5, 32'h77, 32'd0);
    chk("cancel idle start", 64'(start_o), 64'(0));
    step();
    cancel = 1'b0;
    md_sel = 4'd0;
    chk("cancel mthi hi", 64'(hi_o), 64'(1));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
